// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               FSM state encoding, requester IDs and default bus widths.
//               The optional round-robin tie-break is enabled with the
//               DMEM_ARB_RR_EN macro; that macro is used in dmem_arb_pick
//               and dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Three-phase transaction sequencer: sample, strobe memory, collect data
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CORE = 1'b0;
  localparam req_id_t REQ_DBG  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_if
// Description : Bundle of the core port, debug/loader port and data-memory
//               port around the arbiter. The slave modport is the arbiter's
//               view; the master modport is the view of the requesters and
//               the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Core load/store port
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [2:0]        c_funct3;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              c_stall;

  // Debug / loader port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Data-memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_funct3,
    output c_gnt, c_rvalid, c_rdata, c_stall,
    input  d_req, d_we, d_addr, d_wdata, d_funct3,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_funct3,
    input  c_gnt, c_rvalid, c_rdata, c_stall,
    output d_req, d_we, d_addr, d_wdata, d_funct3,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pick
// Description : Combinational winner selection between the core and the
//               debug/loader requester. With DMEM_ARB_RR_EN defined a tie
//               goes to whichever side did not win last; otherwise the core
//               always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic    c_req,
  input  logic    d_req,
`ifdef DMEM_ARB_RR_EN
  input  req_id_t last_winner,
`endif
  output logic    any_req,
  output req_id_t winner
);

  // Pick a winner; a lone requester always wins
  always_comb begin
    any_req = c_req | d_req;
    winner  = REQ_CORE;
    if (c_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
      winner = (last_winner == REQ_CORE) ? REQ_DBG : REQ_CORE;
`else
      winner = REQ_CORE;
`endif
    end else if (d_req) begin
      winner = REQ_DBG;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Serialises core and debug/loader accesses onto the single
//               data-memory port, one transaction per three cycles. Latches
//               the winning request, strobes memory for one cycle, returns
//               read data with a one-cycle valid pulse and stalls the core
//               while its access is outstanding. Define DMEM_ARB_RR_EN for a
//               round-robin tie-break; without it the core wins every tie.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic      clk,
  input  logic      reset,
  dmem_arb_if.slave bus
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_any_req;
  req_id_t           w_winner;
  logic              w_grant;
  logic              w_rd_done;
  logic              w_mem_en;
  logic              w_mem_we;

  req_id_t           r_win_id;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_funct3;

  logic              r_c_gnt;
  logic              r_d_gnt;
  logic              r_c_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_core_rd_pend;

`ifdef DMEM_ARB_RR_EN
  req_id_t           r_last_winner;
`endif

  dmem_arb_pick u_pick (
    .c_req       (bus.c_req),
    .d_req       (bus.d_req),
`ifdef DMEM_ARB_RR_EN
    .last_winner (r_last_winner),
`endif
    .any_req     (w_any_req),
    .winner      (w_winner)
  );

  // Requests are only considered while the sequencer is idle
  assign w_grant   = (r_state == ARB_IDLE) & w_any_req;
  // A read finishes on the RESP->IDLE edge; writes never return data
  assign w_rd_done = (r_state == ARB_RESP) & ~r_we;

  // Next state and memory strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any_req) w_state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        w_mem_en    = 1'b1;
        w_mem_we    = r_we;
        w_state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture the winner's request fields at the grant edge only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_id <= REQ_CORE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= 3'd0;
    end else if (w_grant) begin
      r_win_id <= w_winner;
      if (w_winner == REQ_DBG) begin
        r_we     <= bus.d_we;
        r_addr   <= bus.d_addr;
        r_wdata  <= bus.d_wdata;
        r_funct3 <= bus.d_funct3;
      end else begin
        r_we     <= bus.c_we;
        r_addr   <= bus.c_addr;
        r_wdata  <= bus.c_wdata;
        r_funct3 <= bus.c_funct3;
      end
    end
  end

  // One-cycle grant pulses, coincident with the ACCESS cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_gnt <= 1'b0;
      r_d_gnt <= 1'b0;
    end else begin
      r_c_gnt <= w_grant & (w_winner == REQ_CORE);
      r_d_gnt <= w_grant & (w_winner == REQ_DBG);
    end
  end

  // Register read data into the winner's port and pulse its valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_c_rvalid <= w_rd_done & (r_win_id == REQ_CORE);
      r_d_rvalid <= w_rd_done & (r_win_id == REQ_DBG);
      if (w_rd_done && (r_win_id == REQ_CORE)) r_c_rdata <= bus.mem_rdata;
      if (w_rd_done && (r_win_id == REQ_DBG))  r_d_rdata <= bus.mem_rdata;
    end
  end

  // Core read outstanding from its grant through its rvalid cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_core_rd_pend <= 1'b0;
    end else if (w_grant && (w_winner == REQ_CORE) && !bus.c_we) begin
      r_core_rd_pend <= 1'b1;
    end else if (r_c_rvalid) begin
      r_core_rd_pend <= 1'b0;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember who won the most recent grant for the tie-break
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_last_winner <= REQ_DBG;
    else if (w_grant) r_last_winner <= w_winner;
  end
`endif

  assign bus.c_gnt      = r_c_gnt;
  assign bus.d_gnt      = r_d_gnt;
  assign bus.c_rvalid   = r_c_rvalid;
  assign bus.d_rvalid   = r_d_rvalid;
  assign bus.c_rdata    = r_c_rdata;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.c_stall    = (bus.c_req & ~r_c_gnt) | r_core_rd_pend;
  assign bus.mem_en     = w_mem_en;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_funct3 = r_funct3;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A transaction-level
//               reference model predicts grants and read responses; a
//               monitor compares the DUT against those predictions every
//               cycle. Directed sequences plus a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } gnt_t;

  typedef struct {
    int          cyc;
    bit          port;
    logic [31:0] data;
  } rsp_t;

  gnt_t        gq[$];
  rsp_t        rq[$];
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  int          cyc          = 0;
  int          next_free    = 0;
  int          core_gnt_cyc = -1;
  int          pend_lo      = -1;
  int          pend_hi      = -2;
  bit          last_win     = 1'b1;
  logic [31:0] exp_c_rdata  = '0;
  logic [31:0] exp_d_rdata  = '0;

  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    gq.delete();
    rq.delete();
    next_free    = 0;
    core_gnt_cyc = -1;
    pend_lo      = -1;
    pend_hi      = -2;
    last_win     = 1'b1;
    exp_c_rdata  = '0;
    exp_d_rdata  = '0;
  endtask

  // Reference model: a transaction is granted whenever the arbiter is free
  // (three cycles per transaction) and someone requests; memory effects are
  // applied in grant order.
  always @(posedge clk) begin
    gnt_t g;
    rsp_t r;
    bit   cr, dr, w;
    cyc = cyc + 1;
    if (reset && cyc >= next_free) begin
      cr = bus.c_req;
      dr = bus.d_req;
      if (cr || dr) begin
        if (cr && dr) begin
`ifdef DMEM_ARB_RR_EN
          w = ~last_win;
`else
          w = 1'b0;
`endif
        end else begin
          w = dr;
        end
        last_win = w;
        g.cyc   = cyc;
        g.port  = w;
        g.we    = w ? bus.d_we     : bus.c_we;
        g.addr  = w ? bus.d_addr   : bus.c_addr;
        g.wdata = w ? bus.d_wdata  : bus.c_wdata;
        g.f3    = w ? bus.d_funct3 : bus.c_funct3;
        gq.push_back(g);
        if (g.we) begin
          ref_mem[g.addr[7:2]] = g.wdata;
        end else begin
          r.cyc  = cyc + 2;
          r.port = w;
          r.data = ref_mem[g.addr[7:2]];
          rq.push_back(r);
          if (!w) begin
            pend_lo = cyc;
            pend_hi = cyc + 2;
          end
        end
        if (!w) core_gnt_cyc = cyc;
        next_free = cyc + 3;
      end
    end
  end

  // Memory: read data valid only in the cycle after a read strobe
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    else                           bus.mem_rdata <= $urandom;
  end

  // Monitor: compare every output each cycle against the model's queues
  always @(negedge clk) begin
    gnt_t g;
    rsp_t r;
    bit   ecg, edg, ecr, edr, es;
    if (!reset) begin
      chk("rst_c_gnt",      bus.c_gnt,      0);
      chk("rst_d_gnt",      bus.d_gnt,      0);
      chk("rst_c_rvalid",   bus.c_rvalid,   0);
      chk("rst_d_rvalid",   bus.d_rvalid,   0);
      chk("rst_mem_en",     bus.mem_en,     0);
      chk("rst_mem_we",     bus.mem_we,     0);
      chk("rst_c_rdata",    bus.c_rdata,    0);
      chk("rst_d_rdata",    bus.d_rdata,    0);
      chk("rst_mem_addr",   bus.mem_addr,   0);
      chk("rst_mem_wdata",  bus.mem_wdata,  0);
      chk("rst_mem_funct3", bus.mem_funct3, 0);
      chk("rst_c_stall",    bus.c_stall,    bus.c_req);
    end else begin
      ecg = 1'b0;
      edg = 1'b0;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        g   = gq.pop_front();
        ecg = ~g.port;
        edg = g.port;
        chk("mem_we",     bus.mem_we,     g.we);
        chk("mem_addr",   bus.mem_addr,   g.addr);
        chk("mem_wdata",  bus.mem_wdata,  g.wdata);
        chk("mem_funct3", bus.mem_funct3, g.f3);
      end else begin
        chk("mem_we_idle", bus.mem_we, 0);
      end
      chk("c_gnt",  bus.c_gnt,  ecg);
      chk("d_gnt",  bus.d_gnt,  edg);
      chk("mem_en", bus.mem_en, ecg | edg);

      ecr = 1'b0;
      edr = 1'b0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        if (r.port) begin
          edr = 1'b1;
          exp_d_rdata = r.data;
        end else begin
          ecr = 1'b1;
          exp_c_rdata = r.data;
        end
      end
      chk("c_rvalid", bus.c_rvalid, ecr);
      chk("d_rvalid", bus.d_rvalid, edr);
      chk("c_rdata",  bus.c_rdata,  exp_c_rdata);
      chk("d_rdata",  bus.d_rdata,  exp_d_rdata);

      es = (bus.c_req && core_gnt_cyc != cyc) || (cyc >= pend_lo && cyc <= pend_hi);
      chk("c_stall", bus.c_stall, es);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic drv(input bit p, input bit rqv, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f);
    if (!p) begin
      bus.c_req = rqv; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d; bus.c_funct3 = f;
    end else begin
      bus.d_req = rqv; bus.d_we = we; bus.d_addr = a; bus.d_wdata = d; bus.d_funct3 = f;
    end
  endtask

  task automatic drv_idle(input bit p);
    drv(p, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
  endtask

  task automatic drv_rand(input bit p);
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    drv(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
  endtask

  // Request and hold until granted (bounded), then drop req in the grant cycle
  task automatic issue(input bit p, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f);
    int  n;
    bit  g;
    drv(p, 1'b1, we, a, d, f);
    n = 0;
    g = 1'b0;
    while (!g && n < 20) begin
      tick();
      n++;
      g = p ? bus.d_gnt : bus.c_gnt;
    end
    if (!g) chk("issue_timeout", 0, 1);
    drv_idle(p);
  endtask

  task automatic run(input int n, input int start_pct, input int keep_pct, input int wd_pct);
    bit g, r;
    for (int i = 0; i < n; i++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        g = (p == 1) ? bus.d_gnt : bus.c_gnt;
        r = (p == 1) ? bus.d_req : bus.c_req;
        if (r && g) begin
          if ($urandom_range(0, 99) < keep_pct) drv_rand(p[0]);
          else                                  drv_idle(p[0]);
        end else if (r) begin
          if ($urandom_range(0, 99) < wd_pct) drv_idle(p[0]);
        end else if ($urandom_range(0, 99) < start_pct) begin
          drv_rand(p[0]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    end
    mem[16]     = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;
    drv_idle(1'b0);
    drv_idle(1'b1);
    bus.mem_rdata = '0;

    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Core load from 0x40
    issue(1'b0, 1'b0, 32'h40, 32'h0, 3'b010);
    repeat (3) tick();

    // Debug store to 0x10
    issue(1'b1, 1'b1, 32'h10, 32'h1234_5678, 3'b010);
    repeat (3) tick();

    // Debug request pulsed only while a core access is in ACCESS
    drv(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 3'b100);
    tick();
    chk("wd_core_gnt", bus.c_gnt, 1);
    drv_idle(1'b0);
    drv(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b000);
    tick();
    drv_idle(1'b1);
    repeat (5) tick();

    // Reset asserted while a core read is in RESP
    drv(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
    tick();
    chk("rr_core_gnt", bus.c_gnt, 1);
    drv_idle(1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("arst_c_stall",  bus.c_stall,  0);
    chk("arst_c_rdata",  bus.c_rdata,  0);
    chk("arst_c_rvalid", bus.c_rvalid, 0);
    chk("arst_mem_addr", bus.mem_addr, 0);
    model_reset();

    // Both ports request continuously from reset release
    drv_rand(1'b0);
    drv_rand(1'b1);
    tick();
    tick();
    reset = 1'b1;
    run(15, 100, 100, 0);

    // Randomized traffic with withdrawals and back-to-back requests
    run(3000, 40, 30, 10);

    drv_idle(1'b0);
    drv_idle(1'b1);
    repeat (6) tick();
    chk("gq_drained", gq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
